alu_serial_seq: RTL
===================

ALU_SERIAL_SEQ -- requirements
Module: alu_serial_seq

Interface
- REQ-001: Parameter WIDTH, default 8, operand/result width in bits (WIDTH >= 2) SHALL be supported.
- REQ-002: clk  input  1  rising-edge clock for all state SHALL be provided.
- REQ-003: rst_n  input  1  reset, asynchronous and active-low, SHALL be provided.
- REQ-004: in_valid  input  1  requester presents a command SHALL be provided.
- REQ-005: in_ready  output  1  block can accept a command SHALL be provided.
- REQ-006: s  input  3  opcode, per REQ-014 SHALL be provided.
- REQ-007: a  input  WIDTH  operand A, unsigned, SHALL be provided.
- REQ-008: b  input  WIDTH  operand B, unsigned, SHALL be provided.
- REQ-009: out_valid  output  1  result available SHALL be provided.
- REQ-010: out_ready  input  1  consumer takes the result SHALL be provided.
- REQ-011: result  output  WIDTH  operation result SHALL be provided.
- REQ-012: carry  output  1  carry for add/inc, borrow for sub/dec, 0 for logic ops SHALL be provided.
- REQ-013: zero  output  1  high when result == 0 SHALL be provided.

Function
- REQ-014: The opcode s SHALL map as follows: 000 a+b; 001 a-b; 010 a+1; 011 a-1; 100 a&b; 101 a|b; 110 ~a; 111 a (identity).
- REQ-015: The block SHALL implement an FSM with states IDLE, RUN, and DONE.
- REQ-016: in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
- REQ-017: On a clock edge with in_valid & in_ready, the block SHALL register s, a, and b, clear the bit counter, load the carry seed, and enter RUN.
- REQ-018: Operands, opcode, and carry seed SHALL be captured only at the accept edge; input changes after that edge SHALL have no effect on the current operation.
- REQ-019: In RUN, the block SHALL compute exactly one result bit per cycle, LSB first, using a 1-bit datapath and a 1-bit carry flop, with bit i written at accept edge + 1 + i.
- REQ-020: Arithmetic SHALL be performed as sum_i = a_i ^ op_i ^ c and c' = majority(a_i, op_i, c), with operand and seed selected per opcode:
  - add: op = b, seed 0
  - sub: op = ~b, seed 1
  - inc: op = 0, seed 1
  - dec: op = all-ones, seed 0
- REQ-021: For logic opcodes, the carry flop SHALL be held at 0 and each bit SHALL be computed bitwise from a_i and b_i.
- REQ-022: After bit WIDTH-1, the FSM SHALL enter DONE, giving out_valid high WIDTH edges after the accept edge.
- REQ-023: carry SHALL be set from the final carry flop value c, as follows:
  - add/inc: carry = c
  - sub/dec: carry = ~c, so carry = 1 iff a < b for sub, or iff a == 0 for dec
  - logic ops: carry = 0
- REQ-024: zero SHALL be evaluated on the full final result.
- REQ-025: In DONE, result, carry, and zero SHALL be held stable while out_ready is 0; in_valid SHALL be ignored.
- REQ-026: A clock edge with out_valid & out_ready SHALL return the FSM to IDLE; a new command SHALL NOT be accepted on that same edge.
- REQ-027: The minimum period between successive accepts SHALL be WIDTH+2 cycles.
- REQ-028: result, carry, and zero SHALL retain their last values in IDLE until the next DONE overwrites them.
- REQ-029: Add and sub SHALL wrap modulo 2^WIDTH, as SHALL inc of all-ones and dec of 0.
- REQ-030: in_valid in RUN SHALL be ignored and SHALL NOT corrupt the operation in progress.

Reset
- REQ-031: While rst_n = 0, the block SHALL force state = IDLE, in_ready = 1, out_valid = 0, result = 0, carry = 0, zero = 0, bit counter = 0, and carry flop = 0, independent of clk.
- REQ-032: Reset asserted in RUN or DONE SHALL abandon the operation with no partial result visible after release.
- REQ-033: After rst_n deasserts, the block SHALL be able to accept a command on the first rising edge.

Verification
- REQ-034: The bench SHALL drive WIDTH=8, s=000, a=0xFF, b=0x01 and check result=0x00, carry=1, zero=1, with out_valid rising exactly 8 edges after the accept edge.
- REQ-035: The bench SHALL drive s=001, a=0x05, b=0x07 and check result=0xFE, carry=1, zero=0; it SHALL then drive s=001, a=0x07, b=0x05 and check result=0x02, carry=0.
- REQ-036: The bench SHALL check that s=011, a=0x00 gives result=0xFF, carry=1, and that s=010, a=0xFF gives result=0x00, carry=1, zero=1.
- REQ-037: The bench SHALL check that s=100, a=0xF0, b=0x3C gives 0x30; s=101 gives 0xFC; s=110, a=0xA5 gives 0x5A; and s=111, a=0xA5 gives 0xA5; carry SHALL be 0 for all four.
- REQ-038: The bench SHALL hold out_ready=0 for 5 cycles in DONE and toggle a, b, s, and in_valid, and SHALL check that result/flags are unchanged, in_ready=0, and the return to IDLE occurs one edge after out_ready=1.
- REQ-039: The bench SHALL pulse rst_n low mid-RUN after 3 bits and check that all outputs go to their reset values immediately; the next command, 0x12+0x34, SHALL yield 0x46.

Source files
------------

// File: rtl/alu_serial_seq.sv
// rtl/alu_serial_seq.sv - bit-serial ALU, one result bit per cycle LSB first, valid/ready command and result handshakes
module alu_serial_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       s,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic             c;
    logic [2:0]       op;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;

    logic             accept;
    logic             last_bit;
    logic             seed;
    logic             ai;
    logic             bi;
    logic             opb;
    logic             logic_bit;
    logic             sum;
    logic             c_nxt;
    logic             carry_fin;
    logic [WIDTH-1:0] res_fin;

    assign accept   = in_valid && in_ready;
    assign last_bit = (cnt == CW'(WIDTH - 1));
    // seed is 1 for sub and inc only
    assign seed     = ~s[2] & (s[1] ^ s[0]);

    assign ai = a_sh[0];
    assign bi = b_sh[0];

    always_comb begin
        opb       = 1'b0;
        logic_bit = 1'b0;
        case (op)
            3'b000:  opb = bi;
            3'b001:  opb = ~bi;
            3'b010:  opb = 1'b0;
            3'b011:  opb = 1'b1;
            3'b100:  logic_bit = ai & bi;
            3'b101:  logic_bit = ai | bi;
            3'b110:  logic_bit = ~ai;
            default: logic_bit = ai;
        endcase
    end

    always_comb begin
        sum       = 1'b0;
        c_nxt     = 1'b0;
        carry_fin = 1'b0;
        if (!op[2]) begin
            sum       = ai ^ opb ^ c;
            c_nxt     = (ai & opb) | (ai & c) | (opb & c);
            // sub and dec report a borrow, the inverse of the adder carry
            carry_fin = op[0] ? ~c_nxt : c_nxt;
        end else begin
            sum = logic_bit;
        end
    end

    assign res_fin = {sum, res_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            c      <= 1'b0;
            op     <= 3'b000;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
        end else if (accept) begin
            op   <= s;
            a_sh <= a;
            b_sh <= b;
            cnt  <= '0;
            c    <= seed;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_fin;
            c      <= c_nxt;
            cnt    <= cnt + 1'b1;
            // visible outputs change only when the last bit lands
            if (last_bit) begin
                result <= res_fin;
                carry  <= carry_fin;
                zero   <= (res_fin == '0);
            end
        end
    end

endmodule
